// File: rtl/phy_mem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : phy_mem_access_arbiter
// Brief    : Round-robin arbiter that shares one physical memory port among the
//            I-refill, D-refill and uncachable requesters. It keeps one
//            transaction in flight and rejects IO-flagged addresses.
//            Optional watchdog: define PHY_MEM_ARB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module phy_mem_access_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int PHY_ADDR_WIDTH = 30,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                reqValid,
    input  logic [NUM_REQ*PHY_ADDR_WIDTH-1:0] reqAddr,
    input  logic [NUM_REQ-1:0]                reqWrite,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     reqWData,
    output logic [NUM_REQ-1:0]                reqGrant,
    output logic [NUM_REQ-1:0]                respValid,
    output logic [NUM_REQ-1:0]                respError,
    output logic [DATA_WIDTH-1:0]             respData,
    output logic                              memReq,
    output logic [PHY_ADDR_WIDTH-3:0]         memAddr,
    output logic                              memWrite,
    output logic [DATA_WIDTH-1:0]             memWData,
    input  logic                              memReady,
    input  logic                              memRespValid,
    input  logic [DATA_WIDTH-1:0]             memRData
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RAW_W = PHY_ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [IDX_W-1:0]        r_rrPtr;
    logic [IDX_W-1:0]        r_idx;
    logic [RAW_W-1:0]        r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wData;
    logic [DATA_WIDTH-1:0]   r_rData;
    logic                    r_err;
    logic [NUM_REQ-1:0]      r_grant;

    int                      w_cand;
    logic                    w_winFound;
    logic [IDX_W-1:0]        w_winIdx;
    logic [RAW_W-1:0]        w_winRaw;
    logic                    w_winIo;
    logic [DATA_WIDTH-1:0]   w_winWData;
    logic                    w_wdogExpired;
    logic [NUM_REQ-1:0]      w_idxOneHot;

    // First asserted request at or after the round-robin pointer, with wrap.
    always_comb begin
        w_cand     = 0;
        w_winFound = 1'b0;
        w_winIdx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = int'(r_rrPtr) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!w_winFound && reqValid[w_cand]) begin
                w_winFound = 1'b1;
                w_winIdx   = IDX_W'(w_cand);
            end
        end
        w_winRaw   = reqAddr[w_winIdx*PHY_ADDR_WIDTH +: RAW_W];
        w_winIo    = reqAddr[w_winIdx*PHY_ADDR_WIDTH + RAW_W];
        w_winWData = reqWData[w_winIdx*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef PHY_MEM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0] r_wdog;

    assign w_wdogExpired = ((r_state == ST_ISSUE) || (r_state == ST_WAIT_RD))
                           && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside ISSUE/WAIT_RD so every ISSUE entry starts from zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if ((r_state == ST_ISSUE) || (r_state == ST_WAIT_RD)) begin
            r_wdog <= r_wdog + WD_W'(1);
        end else begin
            r_wdog <= '0;
        end
    end
`else
    assign w_wdogExpired = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_winFound) begin
                    w_nextState = w_winIo ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (memReady) begin
                    w_nextState = r_write ? ST_RESP : ST_WAIT_RD;
                end else if (w_wdogExpired) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_WAIT_RD: begin
                if (memRespValid || w_wdogExpired) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_rrPtr <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wData <= '0;
            r_rData <= '0;
            r_err   <= 1'b0;
            r_grant <= '0;
        end else begin
            r_state <= w_nextState;
            r_grant <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_winFound) begin
                        r_idx   <= w_winIdx;
                        r_addr  <= w_winRaw;
                        r_write <= reqWrite[w_winIdx];
                        r_wData <= w_winWData;
                        r_err   <= w_winIo;
                        r_rData <= '0;
                        r_grant <= NUM_REQ'(1) << w_winIdx;
                    end
                end
                ST_ISSUE: begin
                    if (!memReady && w_wdogExpired) begin
                        r_err   <= 1'b1;
                        r_rData <= '0;
                    end
                end
                ST_WAIT_RD: begin
                    if (memRespValid) begin
                        r_rData <= memRData;
                    end else if (w_wdogExpired) begin
                        r_err   <= 1'b1;
                        r_rData <= '0;
                    end
                end
                ST_RESP: begin
                    r_rrPtr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Memory-side outputs are gated by state so they read zero whenever idle.
    assign w_idxOneHot = NUM_REQ'(1) << r_idx;
    assign reqGrant    = r_grant;
    assign respValid   = (r_state == ST_RESP) ? w_idxOneHot : '0;
    assign respError   = (r_state == ST_RESP && r_err) ? w_idxOneHot : '0;
    assign respData    = (r_state == ST_RESP) ? r_rData : '0;
    assign memReq      = (r_state == ST_ISSUE);
    assign memAddr     = (r_state == ST_ISSUE) ? r_addr : '0;
    assign memWrite    = (r_state == ST_ISSUE) && r_write;
    assign memWData    = (r_state == ST_ISSUE) ? r_wData : '0;

endmodule
`default_nettype wire

// File: tb/tb_phy_mem_access_arbiter.sv
`default_nettype none
// Bench for phy_mem_access_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_phy_mem_access_arbiter;

`ifdef PHY_MEM_ARB_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 256;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  reqValid;
    logic [2:0]  reqWrite;
    logic [29:0] addrR [3];
    logic [31:0] wdR [3];
    logic [89:0] reqAddr;
    logic [95:0] reqWData;
    logic [2:0]  reqGrant, respValid, respError;
    logic [31:0] respData;
    logic        memReq, memWrite, memReady, memRespValid;
    logic [27:0] memAddr;
    logic [31:0] memWData, memRData;

    int nCompared = 0;
    int nMismatched = 0;
    int mPtr = 0;
    bit memAuto = 1'b0;
    bit spurious = 1'b0;
    int readyPct = 100;
    int maxLat = 0;
    int rdDelay = -1;
    logic [31:0] rdQ [$];

    assign reqAddr  = {addrR[2], addrR[1], addrR[0]};
    assign reqWData = {wdR[2], wdR[1], wdR[0]};

    always #5 clk = ~clk;

    phy_mem_access_arbiter #(
        .NUM_REQ(3), .PHY_ADDR_WIDTH(30), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqAddr(reqAddr), .reqWrite(reqWrite), .reqWData(reqWData),
        .reqGrant(reqGrant), .respValid(respValid), .respError(respError), .respData(respData),
        .memReq(memReq), .memAddr(memAddr), .memWrite(memWrite), .memWData(memWData),
        .memReady(memReady), .memRespValid(memRespValid), .memRData(memRData)
    );

    // Spec rule: first requester at or after the pointer, wrapping.
    function automatic int modelWinner(logic [2:0] mask, int ptr);
        for (int k = 0; k < 3; k++) begin
            if (mask[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    // One cycle; in auto mode also plays the downstream memory.
    task automatic step();
        @(negedge clk);
        if (memAuto) begin
            memRespValid = 1'b0;
            if (rdDelay == 0) begin
                memRespValid = 1'b1;
                memRData = $urandom;
                rdQ.push_back(memRData);
                rdDelay = -1;
            end else if (rdDelay > 0) begin
                rdDelay--;
            end else if (spurious && $urandom_range(9, 0) == 0) begin
                memRespValid = 1'b1;
                memRData = $urandom;
            end
            memReady = ($urandom_range(99, 0) < readyPct);
            if (memReq && memReady && !memWrite) rdDelay = $urandom_range(maxLat, 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; memAuto = 1'b0; memReady = 1'b1; memRespValid = 1'b0; memRData = '0;
        reqValid = 3'b111; reqWrite = '0;
        for (int i = 0; i < 3; i++) begin addrR[i] = '0; wdR[i] = '0; end
        repeat (3) step();
        nCompared++;
        if ({reqGrant, respValid, respError, respData, memReq, memAddr, memWrite, memWData} !== '0) begin
            nMismatched++;
            $display("FAIL reset_outputs: grant=%b resp=%b err=%b memReq=%b", reqGrant, respValid, respError, memReq);
        end
        reqValid = '0; rst = 1'b1; mPtr = 0;
        step();
        nCompared++;
        if ({reqGrant, respValid, memReq} !== '0) begin
            nMismatched++;
            $display("FAIL reset_release_idle: grant=%b resp=%b memReq=%b want 0", reqGrant, respValid, memReq);
        end
    endtask

    task automatic test_single_read();
        memAuto = 1'b0; memReady = 1'b1; memRespValid = 1'b0;
        addrR[1] = 30'h0001_0040; reqWrite = 3'b000; reqValid = 3'b010;
        step();
        nCompared++;
        if (reqGrant !== 3'b010) begin
            nMismatched++; $display("FAIL read_grant_t1: got %b want 010", reqGrant);
        end
        nCompared++;
        if (memReq !== 1'b1 || memAddr !== 28'h001_0040 || memWrite !== 1'b0) begin
            nMismatched++; $display("FAIL read_mem_t1: memReq=%b addr=%h wr=%b want 1/0010040/0", memReq, memAddr, memWrite);
        end
        reqValid = '0;
        step();
        nCompared++;
        if (reqGrant !== 3'b000 || respValid !== 3'b000) begin
            nMismatched++; $display("FAIL read_t2_quiet: grant=%b resp=%b want 000/000", reqGrant, respValid);
        end
        memRespValid = 1'b1; memRData = 32'hDEAD_BEEF;
        step();
        memRespValid = 1'b0;
        nCompared++;
        if (respValid !== 3'b010 || respData !== 32'hDEAD_BEEF || respError !== 3'b000) begin
            nMismatched++; $display("FAIL read_resp_t3: valid=%b data=%h err=%b want 010/deadbeef/000", respValid, respData, respError);
        end
        mPtr = (1 + 1) % 3;
        step();
    endtask

    task automatic test_round_robin();
        int grants [$];
        int owners [$];
        int nResp;
        logic [31:0] expD;
        rst = 1'b0; step(); step(); rst = 1'b1; mPtr = 0;
        rdQ.delete(); rdDelay = -1;
        memAuto = 1'b1; spurious = 1'b0; readyPct = 100; maxLat = 0;
        for (int i = 0; i < 3; i++) addrR[i] = {2'b00, 28'($urandom)};
        reqWrite = 3'b000; reqValid = 3'b111; nResp = 0;
        for (int c = 0; c < 80 && nResp < 4; c++) begin
            step();
            if (reqGrant !== 3'b000) begin
                nCompared++;
                if ($countones(reqGrant) != 1) begin
                    nMismatched++; $display("FAIL rr_double_grant: got %b want one-hot", reqGrant);
                end
                for (int i = 0; i < 3; i++) if (reqGrant[i]) grants.push_back(i);
                owners.push_back(modelWinner(3'b111, mPtr));
                mPtr = (owners[$] + 1) % 3;
                if (grants.size() == 4) reqValid = '0;
            end
            if (respValid !== 3'b000) begin
                nResp++;
                expD = (rdQ.size() > 0) ? rdQ.pop_front() : 32'hx;
                nCompared++;
                if (respData !== expD) begin
                    nMismatched++; $display("FAIL rr_resp_data: got %h want %h", respData, expD);
                end
            end
        end
        reqValid = '0;
        nCompared++;
        if (grants.size() != 4 || nResp != 4) begin
            nMismatched++; $display("FAIL rr_count: grants %0d resps %0d want 4/4", grants.size(), nResp);
        end else begin
            for (int i = 0; i < 4; i++) begin
                nCompared++;
                if (grants[i] != owners[i]) begin
                    nMismatched++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, grants[i], owners[i]);
                end
            end
        end
        memAuto = 1'b0; memRespValid = 1'b0;
        step();
    endtask

    task automatic test_store_uncachable();
        bit seen;
        memAuto = 1'b0; memReady = 1'b1; memRespValid = 1'b0;
        addrR[2] = 30'h2000_0100; wdR[2] = 32'h0000_55AA; reqWrite = 3'b100; reqValid = 3'b100;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            step();
            if (reqGrant !== 3'b000) seen = 1'b1;
        end
        reqValid = '0;
        nCompared++;
        if (reqGrant !== 3'b100 || memReq !== 1'b1 || memWrite !== 1'b1 || memWData !== 32'h55AA || memAddr !== 28'h000_0100) begin
            nMismatched++;
            $display("FAIL store_issue: grant=%b req=%b wr=%b wd=%h addr=%h want 100/1/1/55aa/0000100", reqGrant, memReq, memWrite, memWData, memAddr);
        end
        step();
        nCompared++;
        if (respValid !== 3'b100 || respError !== 3'b000) begin
            nMismatched++; $display("FAIL store_ack: valid=%b err=%b want 100/000", respValid, respError);
        end
        mPtr = (2 + 1) % 3;
        reqWrite = '0;
        step();
    endtask

    task automatic test_io_reject();
        bit sawReq, sawGrant, sawResp;
        memAuto = 1'b0; memReady = 1'b1; memRespValid = 1'b0;
        addrR[0] = 30'h1000_2000; reqWrite = 3'b000; reqValid = 3'b001;
        sawReq = 1'b0; sawGrant = 1'b0; sawResp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (memReq === 1'b1) sawReq = 1'b1;
            if (reqGrant !== 3'b000) begin
                sawGrant = 1'b1; reqValid = '0;
                nCompared++;
                if (reqGrant !== 3'b001) begin
                    nMismatched++; $display("FAIL io_grant: got %b want 001", reqGrant);
                end
            end
            if (respValid !== 3'b000 && !sawResp) begin
                sawResp = 1'b1;
                nCompared++;
                if (respValid !== 3'b001 || respError !== 3'b001) begin
                    nMismatched++; $display("FAIL io_resp: valid=%b err=%b want 001/001", respValid, respError);
                end
            end
        end
        nCompared++;
        if (sawReq || !sawGrant || !sawResp) begin
            nMismatched++; $display("FAIL io_flow: memReq %0d grant %0d resp %0d want 0/1/1", sawReq, sawGrant, sawResp);
        end
        mPtr = 1;
    endtask

    task automatic test_stall_and_reset();
        logic [27:0] expA;
        memAuto = 1'b0; memReady = 1'b0; memRespValid = 1'b0;
        expA = 28'($urandom);
        addrR[0] = {2'b00, expA}; reqWrite = 3'b000; reqValid = 3'b001;
        step();
        nCompared++;
        if (reqGrant !== 3'b001) begin
            nMismatched++; $display("FAIL stall_grant: got %b want 001", reqGrant);
        end
        reqValid = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            nCompared++;
            if (memReq !== 1'b1 || memAddr !== expA) begin
                nMismatched++; $display("FAIL stall_hold[%0d]: req=%b addr=%h want 1/%h", c, memReq, memAddr, expA);
            end
        end
        memReady = 1'b1;
        step();
        memReady = 1'b0;
        rst = 1'b0;
        step();
        nCompared++;
        if ({reqGrant, respValid, respError, respData, memReq, memAddr, memWrite, memWData} !== '0) begin
            nMismatched++; $display("FAIL midreset_outputs: grant=%b resp=%b memReq=%b want 0", reqGrant, respValid, memReq);
        end
        rst = 1'b1; mPtr = 0;
        memRespValid = 1'b1; memRData = 32'h1234_5678;
        step();
        memRespValid = 1'b0;
        step();
        nCompared++;
        if (respValid !== 3'b000 || memReq !== 1'b0) begin
            nMismatched++; $display("FAIL midreset_no_resp: resp=%b memReq=%b want 000/0", respValid, memReq);
        end
    endtask

`ifdef PHY_MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit got;
        memAuto = 1'b0; memReady = 1'b1; memRespValid = 1'b0;
        addrR[0] = {2'b00, 28'($urandom)}; reqWrite = 3'b000; reqValid = 3'b001;
        step();
        reqValid = '0;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            step();
            memReady = 1'b0;
            if (respValid !== 3'b000) begin
                got = 1'b1;
                nCompared++;
                if (respValid !== 3'b001 || respError !== 3'b001 || respData !== 32'h0) begin
                    nMismatched++; $display("FAIL timeout_resp: valid=%b err=%b data=%h want 001/001/0", respValid, respError, respData);
                end
            end
        end
        nCompared++;
        if (!got) begin
            nMismatched++; $display("FAIL timeout_never: got no response want error response");
        end
        mPtr = 1;
        memRespValid = 1'b1;
        step();
        memRespValid = 1'b0;
        step();
        nCompared++;
        if (respValid !== 3'b000) begin
            nMismatched++; $display("FAIL timeout_late_data: resp=%b want 000", respValid);
        end
    endtask
`endif

    task automatic test_random();
        int w;
        bit io, gotGrant, gotResp, sawMem;
        logic [2:0] mask;
        logic [31:0] expD;
        rdQ.delete(); rdDelay = -1; memRespValid = 1'b0;
        memAuto = 1'b1; spurious = 1'b1;
`ifdef PHY_MEM_ARB_TIMEOUT_EN
        readyPct = 100; maxLat = 2;
`else
        readyPct = 60; maxLat = 4;
`endif
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 3; i++) begin
                addrR[i] = {1'($urandom_range(1, 0)), ($urandom_range(4, 0) == 0), 28'($urandom)};
                wdR[i] = $urandom;
            end
            reqWrite = 3'($urandom);
            mask = 3'($urandom_range(7, 1));
            w = modelWinner(mask, mPtr);
            io = addrR[w][28];
            reqValid = mask;
            gotGrant = 1'b0; gotResp = 1'b0; sawMem = 1'b0;
            for (int c = 0; c < 60 && !gotResp; c++) begin
                step();
                if (reqGrant !== 3'b000) begin
                    nCompared++;
                    if (reqGrant !== 3'(1 << w) || gotGrant) begin
                        nMismatched++; $display("FAIL rand_grant[%0d]: got %b want %b", t, reqGrant, 3'(1 << w));
                    end
                    gotGrant = 1'b1; reqValid = '0;
                end
                if (memReq === 1'b1 && memReady === 1'b1) begin
                    sawMem = 1'b1;
                    nCompared++;
                    if (memAddr !== addrR[w][27:0] || memWrite !== reqWrite[w] || memWData !== wdR[w]) begin
                        nMismatched++;
                        $display("FAIL rand_mem[%0d]: addr=%h wr=%b wd=%h want %h/%b/%h", t, memAddr, memWrite, memWData, addrR[w][27:0], reqWrite[w], wdR[w]);
                    end
                end
                if (respValid !== 3'b000) begin
                    gotResp = 1'b1;
                    nCompared++;
                    if (respValid !== 3'(1 << w) || respError !== (io ? 3'(1 << w) : 3'b000)) begin
                        nMismatched++; $display("FAIL rand_resp[%0d]: valid=%b err=%b want owner %0d io %0d", t, respValid, respError, w, io);
                    end
                    if (!io && !reqWrite[w]) begin
                        expD = (rdQ.size() > 0) ? rdQ.pop_front() : 32'hx;
                        nCompared++;
                        if (respData !== expD) begin
                            nMismatched++; $display("FAIL rand_data[%0d]: got %h want %h", t, respData, expD);
                        end
                    end
                end
            end
            nCompared++;
            if (!gotGrant || !gotResp || sawMem == io) begin
                nMismatched++; $display("FAIL rand_flow[%0d]: grant %0d resp %0d mem %0d io %0d", t, gotGrant, gotResp, sawMem, io);
            end
            reqValid = '0;
            mPtr = (w + 1) % 3;
        end
        memAuto = 1'b0; memRespValid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_store_uncachable();
        test_io_reject();
        test_stall_and_reset();
`ifdef PHY_MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
